// File: rtl/adder49_arbiter_pkg.sv
// Shared widths, FSM state encoding and operand bundle for the adder arbiter.
// Operand B is narrower than A and is zero-extended before the add.
package adder49_arbiter_pkg;

    localparam int A_W   = 49;
    localparam int B_W   = 34;
    localparam int SUM_W = 50;

    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_FULL = 1'b1;

    typedef struct packed {
        logic [A_W-1:0] a;
        logic [B_W-1:0] b;
    } opnd_t;

endpackage

// File: rtl/adder49_arbiter_if.sv
// Request/response bundle between requesters, the consumer and the shared adder arbiter.
// master = requester/consumer side, slave = arbiter side.
interface adder49_arbiter_if
    import adder49_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ*A_W-1:0] req_a;
    logic [NUM_REQ*B_W-1:0] req_b;
    logic [NUM_REQ-1:0]     req_ready;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [SUM_W-1:0]       rsp_sum;
    logic [ID_W-1:0]        rsp_id;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_id
    );
endinterface

// File: rtl/adder49_arbiter_adder.sv
// Existing 49-bit adder with carry-out; callers zero-extend the 34-bit operand (top 15 bits zero).
// Purely combinational, no backpressure.
module customAdder49_15
    import adder49_arbiter_pkg::*;
(
    input  logic [A_W-1:0]   a,
    input  logic [A_W-1:0]   b,
    output logic [SUM_W-1:0] sum
);
    assign sum = {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/adder49_arbiter.sv
// Round-robin share of one adder among NUM_REQ requesters; result appears one cycle after grant.
// Grants only when the result register is empty or draining this cycle; holds result while rsp_ready is low.
module adder49_arbiter
    import adder49_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input logic             clk,
    input logic             rst_n,
    adder49_arbiter_if.slave bus
);
    state_t             state;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    gnt_id;
    logic [ID_W-1:0]    cand;
    logic               found;
    logic               grant_ok;
    logic               grant;
    logic [NUM_REQ-1:0] gnt_vec;
    opnd_t              opnd;
    logic [SUM_W-1:0]   sum_nxt;
    logic [SUM_W-1:0]   sum_q;
    logic [ID_W-1:0]    id_q;

    // First valid requester at or after rr_ptr, wrapping; depends only on req_valid and rr_ptr.
    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (int'(rr_ptr) + k >= NUM_REQ) begin
                cand = ID_W'(int'(rr_ptr) + k - NUM_REQ);
            end else begin
                cand = ID_W'(int'(rr_ptr) + k);
            end
            if (!found && bus.req_valid[cand]) begin
                found  = 1'b1;
                gnt_id = cand;
            end
        end
    end

    assign grant_ok = rst_n && ((state == ST_IDLE) || bus.rsp_ready);
    assign grant    = found && grant_ok;

    always_comb begin
        gnt_vec = '0;
        if (grant) begin
            gnt_vec[gnt_id] = 1'b1;
        end
    end

    assign opnd.a = bus.req_a[gnt_id*A_W +: A_W];
    assign opnd.b = bus.req_b[gnt_id*B_W +: B_W];

    customAdder49_15 u_adder (
        .a   ({{(A_W-B_W){1'b0}}, opnd.b} == '0 ? opnd.a : opnd.a),
        .b   ({{(A_W-B_W){1'b0}}, opnd.b}),
        .sum (sum_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            rr_ptr <= '0;
            sum_q  <= '0;
            id_q   <= '0;
        end else if (grant) begin
            state  <= ST_FULL;
            sum_q  <= sum_nxt;
            id_q   <= gnt_id;
            rr_ptr <= (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
        end else if ((state == ST_FULL) && bus.rsp_ready) begin
            state <= ST_IDLE;
        end
    end

    assign bus.req_ready = gnt_vec;
    assign bus.rsp_valid = (state == ST_FULL);
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_id    = id_q;

endmodule

// File: tb/tb_adder49_arbiter.sv
// Directed vector table plus hand sequences for backpressure and mid-operation reset.
module tb_adder49_arbiter;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    adder49_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus ();

    adder49_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  vld;
        logic        rdy;
        logic [48:0] a;
        logic [33:0] b;
        logic [3:0]  exp_ready;
        logic        exp_valid;
        logic [49:0] exp_sum;
        logic [1:0]  exp_id;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [49:0] act, input logic [49:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Lane i sees a+1000*i and b+i, so a granted lane's sum is a+b+1001*i.
    task automatic drive(input logic [3:0] v, input logic r, input logic [48:0] a, input logic [33:0] b);
        bus.req_valid = v;
        bus.rsp_ready = r;
        for (int i = 0; i < 4; i++) begin
            bus.req_a[i*49 +: 49] = a + 49'(1000*i);
            bus.req_b[i*34 +: 34] = b + 34'(i);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        tbl[0]  = '{4'b1111, 1'b1, 49'd100, 34'd10, 4'b0001, 1'b1, 50'd110,  2'd0};
        tbl[1]  = '{4'b1111, 1'b1, 49'd100, 34'd10, 4'b0010, 1'b1, 50'd1111, 2'd1};
        tbl[2]  = '{4'b1111, 1'b1, 49'd100, 34'd10, 4'b0100, 1'b1, 50'd2112, 2'd2};
        tbl[3]  = '{4'b1111, 1'b1, 49'd100, 34'd10, 4'b1000, 1'b1, 50'd3113, 2'd3};
        tbl[4]  = '{4'b1111, 1'b1, 49'd100, 34'd10, 4'b0001, 1'b1, 50'd110,  2'd0};
        tbl[5]  = '{4'b0000, 1'b1, 49'd100, 34'd10, 4'b0000, 1'b0, 50'd110,  2'd0};
        tbl[6]  = '{4'b0001, 1'b1, 49'd5,   34'd3,  4'b0001, 1'b1, 50'd8,    2'd0};
        tbl[7]  = '{4'b1111, 1'b0, 49'd5,   34'd3,  4'b0000, 1'b1, 50'd8,    2'd0};
        tbl[8]  = '{4'b1111, 1'b0, 49'd5,   34'd3,  4'b0000, 1'b1, 50'd8,    2'd0};
        tbl[9]  = '{4'b1111, 1'b0, 49'd5,   34'd3,  4'b0000, 1'b1, 50'd8,    2'd0};
        tbl[10] = '{4'b1111, 1'b1, 49'd5,   34'd3,  4'b0010, 1'b1, 50'd1009, 2'd1};
        tbl[11] = '{4'b0100, 1'b0, 49'd5,   34'd3,  4'b0000, 1'b1, 50'd1009, 2'd1};
        tbl[12] = '{4'b1001, 1'b1, 49'd5,   34'd3,  4'b1000, 1'b1, 50'd3011, 2'd3};
        tbl[13] = '{4'b1010, 1'b1, 49'd5,   34'd3,  4'b0010, 1'b1, 50'd1009, 2'd1};
        tbl[14] = '{4'b0001, 1'b1, 49'h1FFFFFFFFFFFF, 34'h3FFFFFFFF,
                    4'b0001, 1'b1, 50'h20003FFFFFFFE, 2'd0};
        tbl[15] = '{4'b0000, 1'b1, 49'd5,   34'd3,  4'b0000, 1'b0, 50'd0,    2'd0};

        rst_n = 1'b0;
        drive(4'b1111, 1'b1, 49'd100, 34'd10);
        #2;
        chk("reset_req_ready", 50'(bus.req_ready), 50'd0);
        chk("reset_rsp_valid", 50'(bus.rsp_valid), 50'd0);
        chk("reset_rsp_sum",   bus.rsp_sum,        50'd0);
        chk("reset_rsp_id",    50'(bus.rsp_id),    50'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 16; v++) begin
            drive(tbl[v].vld, tbl[v].rdy, tbl[v].a, tbl[v].b);
            #1;
            chk($sformatf("v%0d_req_ready", v), 50'(bus.req_ready), 50'(tbl[v].exp_ready));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_rsp_valid", v), 50'(bus.rsp_valid), 50'(tbl[v].exp_valid));
            if (tbl[v].exp_valid) begin
                chk($sformatf("v%0d_rsp_sum", v), bus.rsp_sum,       tbl[v].exp_sum);
                chk($sformatf("v%0d_rsp_id", v),  50'(bus.rsp_id),   50'(tbl[v].exp_id));
            end
            @(negedge clk);
        end

        // Fill the result register from lane 2, then reset while it is held.
        drive(4'b0100, 1'b0, 49'd5, 34'd3);
        #1;
        chk("rst_seq_grant2", 50'(bus.req_ready), 50'b0100);
        @(posedge clk);
        #1;
        chk("rst_seq_sum2", bus.rsp_sum,     50'd2010);
        chk("rst_seq_id2",  50'(bus.rsp_id), 50'd2);
        @(negedge clk);
        drive(4'b1111, 1'b0, 49'd5, 34'd3);
        #1;
        chk("rst_seq_hold_ready", 50'(bus.req_ready), 50'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 50'(bus.rsp_valid), 50'd0);
        chk("async_rst_sum",   bus.rsp_sum,        50'd0);
        chk("async_rst_id",    50'(bus.rsp_id),    50'd0);
        chk("async_rst_ready", 50'(bus.req_ready), 50'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_grant0", 50'(bus.req_ready), 50'b0001);
        @(posedge clk);
        #1;
        chk("post_rst_valid", 50'(bus.rsp_valid), 50'd1);
        chk("post_rst_sum",   bus.rsp_sum,        50'd8);
        chk("post_rst_id",    50'(bus.rsp_id),    50'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
